// File: rtl/ib_lut_ram_loader.sv
// rtl/ib_lut_ram_loader.sv - packs streamed LUT entries into IB-CNU RAM page writes
// One load fills every page of the selected multi-frame half, BANK_NUM entries per page.
module ib_lut_ram_loader #(
  parameter int QUAN_SIZE       = 4,
  parameter int LUT_PORT_SIZE   = 3,
  parameter int BANK_NUM        = 2,
  parameter int ENTRY_ADDR      = 6,
  parameter int MULTI_FRAME_NUM = 2
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic                              frame_offset,
  input  logic [LUT_PORT_SIZE-1:0]          lut_in_data,
  input  logic                              lut_in_valid,
  output logic                              lut_in_ready,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data,
  output logic                              ib_ram_we,
  output logic                              load_busy,
  output logic                              load_done
);

  // QUAN_SIZE only rides along for the integrating level; it does not shape any logic here.
  localparam int PAGE_W = ENTRY_ADDR - MULTI_FRAME_NUM + 1 + 0 * QUAN_SIZE;
  localparam int WORD_W = LUT_PORT_SIZE * BANK_NUM;
  localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                offset_q, offset_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [ENTRY_ADDR-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  logic [WORD_W-1:0]   word_next;

  // Earlier entries shift toward the MSBs, so bank0 ends up in the upper slice.
  assign word_next = WORD_W'({shreg_q, lut_in_data});

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    bank_d   = bank_q;
    offset_d = offset_q;
    shreg_d  = shreg_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d  = LOAD;
          page_d   = '0;
          bank_d   = '0;
          offset_d = frame_offset;
          shreg_d  = '0;
        end
      end
      LOAD: begin
        if (lut_in_valid) begin
          shreg_d = word_next;
          if (bank_q == BANK_W'(BANK_NUM - 1)) begin
            bank_d = '0;
            we_d   = 1'b1;
            addr_d = ENTRY_ADDR'({offset_q, page_q});
            data_d = word_next;
            page_d = page_q + PAGE_W'(1);
            if (page_q == '1) state_d = FLUSH;
          end else begin
            bank_d = bank_q + BANK_W'(1);
          end
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d  = IDLE;
      page_d   = '0;
      bank_d   = '0;
      offset_d = 1'b0;
      shreg_d  = '0;
      addr_d   = '0;
      data_d   = '0;
      we_d     = 1'b0;
    end
  end

  always_ff @(posedge write_clk) begin
    state_q  <= state_d;
    page_q   <= page_d;
    bank_q   <= bank_d;
    offset_q <= offset_d;
    shreg_q  <= shreg_d;
    addr_q   <= addr_d;
    data_q   <= data_d;
    we_q     <= we_d;
  end

  // Outputs are forced low for the whole reset window, not just after the first edge.
  assign lut_in_ready   = !rst && (state_q == LOAD);
  assign load_busy      = !rst && (state_q != IDLE);
  assign load_done      = !rst && (state_q == DONE);
  assign ib_ram_we      = !rst && we_q;
  assign page_addr_ram  = rst ? '0 : addr_q;
  assign ram_write_data = rst ? '0 : data_q;

endmodule

// File: tb/tb_ib_lut_ram_loader.sv
// tb/tb_ib_lut_ram_loader.sv - scoreboard bench for ib_lut_ram_loader
module tb_ib_lut_ram_loader;

  logic       write_clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       frame_offset = 1'b0;
  logic [2:0] lut_in_data = '0;
  logic       lut_in_valid = 1'b0;
  logic       lut_in_ready;
  logic [5:0] page_addr_ram;
  logic [5:0] ram_write_data;
  logic       ib_ram_we;
  logic       load_busy;
  logic       load_done;

  ib_lut_ram_loader dut (
    .write_clk      (write_clk),
    .rst            (rst),
    .load_start     (load_start),
    .frame_offset   (frame_offset),
    .lut_in_data    (lut_in_data),
    .lut_in_valid   (lut_in_valid),
    .lut_in_ready   (lut_in_ready),
    .page_addr_ram  (page_addr_ram),
    .ram_write_data (ram_write_data),
    .ib_ram_we      (ib_ram_we),
    .load_busy      (load_busy),
    .load_done      (load_done)
  );

  always #5 write_clk = ~write_clk;

  typedef struct {
    logic [5:0] addr;
    logic [5:0] data;
    int         due;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fails  = 0;
  int  cyc      = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;

  always @(posedge write_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] entry(input int mode, input int k);
    case (mode)
      0:       return 3'(k % 8);
      1:       return (k % 2 == 0) ? 3'b101 : 3'b010;
      default: return 3'((k * 3 + 1) % 8);
    endcase
  endfunction

  always @(negedge write_clk) begin
    wr_t e;
    if (ib_ram_we === 1'b1) begin
      wr_cnt++;
      if (sb.size() == 0) check("unexpected_we", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("wr_addr", 32'(page_addr_ram), 32'(e.addr));
        check("wr_data", 32'(ram_write_data), 32'(e.data));
        check("wr_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      check("missed_write", 32'(cyc), 32'(sb[0].due));
      e = sb.pop_front();
    end
    if (load_done === 1'b1) done_cnt++;
  end

  // stop_after >= 0 abandons the load after that many handshakes; ls_at pulses load_start mid-load.
  task automatic do_load(input logic off, input int mode, input bit stall, input int stop_after,
                         input int ls_at, input bit ls_done);
    int k, page, budget, wr0, dn0;
    logic [2:0] prev;
    wr_t e;
    wr0 = wr_cnt; dn0 = done_cnt;
    k = 0; page = 0; budget = 0; prev = '0;
    @(posedge write_clk); #1;
    load_start = 1'b1; frame_offset = off;
    @(posedge write_clk); #1;
    load_start = 1'b0; frame_offset = ~off;
    lut_in_valid = 1'b0;
    while (k < 64 && k != stop_after && budget < 400) begin
      lut_in_valid = stall ? ~lut_in_valid : 1'b1;
      lut_in_data  = entry(mode, k);
      load_start   = (k == ls_at);
      @(negedge write_clk);
      if (k % 16 == 0 || !stall) check("ready_in_load", 32'(lut_in_ready), 32'd1);
      if (k == 0) check("busy_in_load", 32'(load_busy), 32'd1);
      if (lut_in_valid) begin
        if (k % 2 == 1) begin
          e.addr = {off, 5'(page)};
          e.data = {prev, lut_in_data};
          e.due  = cyc + 1;
          sb.push_back(e);
          page++;
        end
        prev = lut_in_data;
        k++;
      end
      budget++;
      @(posedge write_clk); #1;
    end
    lut_in_valid = 1'b0; load_start = 1'b0;
    if (budget >= 400) check("load_timeout", 32'(k), 32'd64);
    if (stop_after >= 0) return;
    @(negedge write_clk);
    check("flush_ready", 32'(lut_in_ready), 32'd0);
    check("flush_busy", 32'(load_busy), 32'd1);
    check("flush_done", 32'(load_done), 32'd0);
    @(posedge write_clk); #1;
    if (ls_done) load_start = 1'b1;
    @(negedge write_clk);
    check("done_pulse", 32'(load_done), 32'd1);
    @(posedge write_clk); #1;
    load_start = 1'b0;
    @(negedge write_clk);
    check("idle_done", 32'(load_done), 32'd0);
    check("idle_busy", 32'(load_busy), 32'd0);
    check("write_count", 32'(wr_cnt - wr0), 32'd32);
    check("done_count", 32'(done_cnt - dn0), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"}, 32'(ib_ram_we), 32'd0);
    check({tag, "_ready"}, 32'(lut_in_ready), 32'd0);
    check({tag, "_busy"}, 32'(load_busy), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_addr"}, 32'(page_addr_ram), 32'd0);
    check({tag, "_data"}, 32'(ram_write_data), 32'd0);
  endtask

  initial begin
    int wr0;
    // reset wins over a simultaneous load_start
    rst = 1'b1; load_start = 1'b1;
    repeat (3) @(posedge write_clk);
    @(negedge write_clk);
    check_outputs_zero("in_reset");
    #1 load_start = 1'b0;
    @(posedge write_clk); #1;
    rst = 1'b0;
    @(negedge write_clk);
    check_outputs_zero("after_reset");

    do_load(1'b0, 0, 1'b0, -1, -1, 1'b0);
    do_load(1'b1, 1, 1'b0, -1, -1, 1'b0);
    do_load(1'b0, 2, 1'b1, -1, -1, 1'b0);

    // reset after 10 full pages plus one bank0 entry
    wr0 = wr_cnt;
    do_load(1'b1, 0, 1'b0, 21, -1, 1'b0);
    rst = 1'b1;
    @(negedge write_clk);
    check_outputs_zero("midload_rst");
    @(posedge write_clk); #1;
    rst = 1'b0;
    @(negedge write_clk);
    check_outputs_zero("post_midload_rst");
    repeat (3) @(negedge write_clk);
    check("partial_writes", 32'(wr_cnt - wr0), 32'd10);
    check("partial_sb_empty", 32'(sb.size()), 32'd0);

    do_load(1'b0, 0, 1'b0, -1, -1, 1'b0);
    do_load(1'b1, 2, 1'b0, -1, 10, 1'b1);

    repeat (4) @(negedge write_clk);
    check("final_idle_busy", 32'(load_busy), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
